// File: rtl/view_ray_scheduler.sv
// Per-frame column sweep: latches the player view, issues one ray per screen column
// to the view_ray datapath, captures each result and streams it to the column consumer.
module view_ray_scheduler #(
  parameter int unsigned COLS = 64,
  parameter int unsigned LAT  = 4,
  parameter int unsigned STEP = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [30:0]              base_normal,
  input  logic [7:0]               base_dist,
  input  logic [12:0]              base_loc,
  output logic [30:0]              ray_normal,
  output logic [7:0]               ray_dist,
  output logic [12:0]              ray_loc,
  input  logic [30:0]              ray_result,
  output logic                     col_valid,
  output logic [$clog2(COLS)-1:0]  col_index,
  output logic [30:0]              col_data,
  input  logic                     col_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned WW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [9:0]    STEP_X    = 10'(STEP);
  localparam logic [9:0]    HALF_X    = 10'((STEP * COLS) / 2);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] col_q, col_n;
  logic [WW-1:0] wait_q, wait_n;
  logic [30:0]   nrm_q, nrm_n;
  logic [7:0]    dist_q, dist_n;
  logic [12:0]   loc_q, loc_n;

  logic [30:0]   ray_normal_n;
  logic [7:0]    ray_dist_n;
  logic [12:0]   ray_loc_n;
  logic          col_valid_n;
  logic [CW-1:0] col_index_n;
  logic [30:0]   col_data_n;
  logic          busy_n;
  logic          frame_done_n;

  // Column ray x: centred on the view x, STEP apart, wrapping in 10 bits.
  function automatic logic [9:0] col_x(input logic [9:0] x, input logic [CW-1:0] c);
    return x + STEP_X * 10'(c) - HALF_X;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      wait_q     <= '0;
      nrm_q      <= '0;
      dist_q     <= '0;
      loc_q      <= '0;
      ray_normal <= '0;
      ray_dist   <= '0;
      ray_loc    <= '0;
      col_valid  <= 1'b0;
      col_index  <= '0;
      col_data   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_n;
      col_q      <= col_n;
      wait_q     <= wait_n;
      nrm_q      <= nrm_n;
      dist_q     <= dist_n;
      loc_q      <= loc_n;
      ray_normal <= ray_normal_n;
      ray_dist   <= ray_dist_n;
      ray_loc    <= ray_loc_n;
      col_valid  <= col_valid_n;
      col_index  <= col_index_n;
      col_data   <= col_data_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
    end
  end

  // ray_* are loaded on entry to ISSUE so the datapath sees them for the whole column.
  always_comb begin
    state_n      = state_q;
    col_n        = col_q;
    wait_n       = wait_q;
    nrm_n        = nrm_q;
    dist_n       = dist_q;
    loc_n        = loc_q;
    ray_normal_n = ray_normal;
    ray_dist_n   = ray_dist;
    ray_loc_n    = ray_loc;
    col_valid_n  = col_valid;
    col_index_n  = col_index;
    col_data_n   = col_data;
    busy_n       = busy;
    frame_done_n = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          nrm_n        = base_normal;
          dist_n       = base_dist;
          loc_n        = base_loc;
          col_n        = '0;
          ray_normal_n = {col_x(base_normal[30:21], '0), base_normal[20:0]};
          ray_dist_n   = base_dist;
          ray_loc_n    = base_loc;
          busy_n       = 1'b1;
          state_n      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wait_n  = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LAST_WAIT) begin
          col_data_n  = ray_result;
          col_index_n = col_q;
          col_valid_n = 1'b1;
          state_n     = S_EMIT;
        end else begin
          wait_n = WW'(wait_q + 1'b1);
        end
      end
      S_EMIT: begin
        if (col_ready) begin
          col_valid_n = 1'b0;
          if (col_q == LAST_COL) begin
            frame_done_n = 1'b1;
            state_n      = S_DONE;
          end else begin
            col_n        = CW'(col_q + 1'b1);
            ray_normal_n = {col_x(nrm_q[30:21], CW'(col_q + 1'b1)), nrm_q[20:0]};
            state_n      = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/view_ray_scheduler.md
Name: view_ray_scheduler

Overview:
- Sequences the per-column ray sweep for one rendered frame.
- On a frame request, latches the player view (normal, distance, location) and walks COLS screen columns.
- For each column it derives a ray normal by offsetting the x field, drives the view_ray datapath, waits its fixed latency, and captures the result.
- Streams each captured result to the column consumer (frame/column buffer) over a valid/ready handshake.

Parameters:
- COLS, 64, columns per frame (power of two, 2..1024).
- LAT, 4, view_ray latency in clk cycles from stable inputs to valid view_out (>=1).
- STEP, 4, unsigned x-field increment per column.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle frame request pulse.
- base_normal  in  31  view normal, format {x[9:0], y[9:0], z[10:0]} = bits [30:21], [20:11], [10:0].
- base_dist  in  8  view distance.
- base_loc  in  13  player location.
- ray_normal  out  31  to view_ray view_normal.
- ray_dist  out  8  to view_ray view_dist.
- ray_loc  out  13  to view_ray view_loc.
- ray_result  in  31  from view_ray view_out.
- col_valid  out  1  column result valid.
- col_index  out  log2(COLS)  column number of col_data.
- col_data  out  31  captured ray_result.
- col_ready  in  1  consumer accepts when col_valid && col_ready.
- busy  out  1  high from the cycle after an accepted frame_start through the DONE state.
- frame_done  out  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including ray_*, col_valid, col_index, col_data, busy, frame_done. Column counter, wait counter and latched view cleared.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued, and the in-flight column is dropped.
- IDLE:
  - A frame_start seen in IDLE latches base_normal, base_dist and base_loc, sets col=0, and goes to ISSUE.
  - frame_start in any other state is ignored, and the latched values do not change.
- ISSUE (1 cycle):
  - ray_normal = {x_c, y_latched, z_latched}, ray_dist = latched dist, ray_loc = latched loc. Go to WAIT, wait counter = 0.
  - x_c = (x_latched + STEP*col - STEP*COLS/2) mod 1024; 10-bit wrap, no saturation.
  - ray_* are registered and held constant from ISSUE through EMIT of that column.
- WAIT (LAT cycles): the counter increments each cycle. On the LAT-th cycle, ray_result is captured into col_data, col_index=col, and the state goes to EMIT.
- EMIT:
  - col_valid=1; col_data and col_index are held stable while col_ready=0 (no timeout).
  - On handshake, col_valid drops the next cycle.
  - If col==COLS-1, go to DONE; otherwise col+1 and go to ISSUE.
- DONE (1 cycle): frame_done=1, busy=1, then IDLE with busy=0.
- Timing with col_ready held high: LAT+2 cycles per column, COLS*(LAT+2)+1 cycles from the cycle after frame_start to the frame_done pulse.
- frame_start in the same cycle as DONE is ignored. A new frame may start on the first IDLE cycle.
- Outputs stay at their last values in IDLE; only col_valid and frame_done return to 0.

Test Plan:
- Reset: hold rst=0 and toggle clk -> all outputs 0, busy=0. Pulse rst low mid-frame at col 10 -> next edge: state IDLE, col_valid=0, no frame_done.
- Nominal frame: base_normal=31'b0011111111100111111111000000000 (x=255, y=639, z=1536), dist=3, loc=13'b0111110111111, col_ready=1, stub view_ray echoing inputs delayed by 4 -> 64 handshakes with col_index 0..63.
  - col 0 ray x=127, col 63 ray x=379, y/z unchanged.
  - frame_done at cycle 385 after frame_start.
- Wrap-around: base x=1000 -> col 0 x=872, col 32 x=1000, col 63 x=100.
- Backpressure: col_ready=0 for 7 cycles at col 5 -> col_valid, col_data and col_index stable for all 7 cycles, ray_* unchanged. Frame completes 7 cycles late with no column lost or duplicated.
- Ignored request: pulse frame_start with a different base_normal at col 20 -> latched view unchanged, single frame_done. A frame_start one cycle after frame_done starts a new frame with the new values.
- Latency parameter: LAT=1 with a matching stub -> 3 cycles per column, col_data equals the stub output for the same column.
